read_data_control: RTL
======================

Name: read_data_control

Overview:
- AFU-side receiver for the PSL buffer-write interface (ha_bwvalid/bwtag/bwtagpar/bwad/bwdata/bwpar), which carries read-command data into the AFU.
- Each tag's 128B cache line arrives as two 64B halves, in either order and interleaved with other tags; halves are stored per tag.
- Emits the full assembled line once both halves are present.
- Checks tag and data parity; reports errors to the AFU error aggregator.

Parameters:
- TAG_DEPTH, 256, tracked tags (tag width 8).
- ENABLE_ERRORS, 1, 0 forces data_read_error to 0.

Ports:
- clock  in  1  clock
- rstn  in  1  asynchronous active-low reset
- enabled_in  in  1  block enable (registered internally)
- bw_valid  in  1  ha_bwvalid
- bw_tag  in  8  ha_bwtag
- bw_tag_parity  in  1  ha_bwtagpar, odd
- bw_address  in  6  ha_bwad; 0 = half 0, nonzero = half 1
- bw_data  in  512  ha_bwdata
- bw_parity  in  8  ha_bwpar, odd, one bit per 64-bit doubleword (bit 0 covers data[0:63])
- line_valid  out  1  assembled line valid, one-cycle pulse
- line_tag  out  8  tag of assembled line
- line_data_0  out  512  half 0 data
- line_data_1  out  512  half 1 data
- line_parity_error  out  1  either half of this line had a data parity error
- data_read_error  out  3  {tag_parity, data_parity, duplicate_half}, registered

Behaviour:
- Reset: all outputs 0; both half-seen bitmaps, the per-tag error bitmap and all pipeline valids 0. RAM contents are not reset.
- enabled is enabled_in delayed 1 cycle.
- S0: a beat with bw_valid=1 while enabled=1 is latched into the stage-0 registers; otherwise the stage-0 valid is 0.
  - Disabling drops new beats.
  - Disabling does not clear the bitmaps; an in-flight pipeline drains normally.
- S1, tag and data checks:
  - Recompute odd parity over the tag; mismatch gives tag_err.
  - Recompute 8 doubleword parities; any mismatch gives data_err.
  - half = |bw_address.
- S1, half-seen bitmaps (seen0[tag], seen1[tag]):
  - tag_err: beat discarded. No RAM write, no bitmap change.
  - Else, write data into the half-h RAM at tag. If the other half is already seen, mark a completion and clear both bits. Else set seen_h[tag].
  - Duplicate (seen_h[tag] already 1, other half not seen): overwrite data, keep the bit set, raise dup_err.
- S1, per-tag error bit:
  - OR data_err into err[tag].
  - The error bit clears on completion and is ORed into line_parity_error.
- S2, completion read:
  - Registered RAM read of the other half at the completing tag.
  - The incoming half is carried in a register alongside.
  - Forwarding is required: if the previous cycle's S1 RAM write hit the same tag and the same half being read, use the written data instead of the RAM output.
  - This covers back-to-back halves of one tag.
- Latency: line_valid is asserted exactly 3 cycles after the bw_valid of the completing half.
  - line_data_0/1 are ordered by half, not by arrival order.
  - Outputs hold their last value when line_valid=0.
- Throughput: one beat per cycle; at most one completion per cycle; no backpressure.
- Error pipeline:
  - S1 flags are registered into detected_errors.
  - data_read_error = ENABLE_ERRORS ? detected_errors : 0, registered.
  - Total: 3 cycles after the offending beat; each flag is a one-cycle pulse per bad beat.
- Reset mid-line: half-received tags are forgotten. A later single half sets its bit afresh and does not complete.

Decomposition:
- GLOBALS/AFU package:
  - ReadDataControlInterface typedef (the bw_* fields).
  - ReadDataLineOut typedef (valid, tag, data_0, data_1, parity_error).
  - READ_DATA_LATENCY=3 constant.
  - Reuses ReadWriteDataLine.
- Sub-modules: two instances of the existing ram (width 512, depth TAG_DEPTH), dw_parity (DOUBLE_WORDS=8) and parity (BITS=8).
- Control and forwarding logic stay in this module.

Test Plan:
- Tag 0x05, half 0 at cycle N then half 1 at N+4, correct parity -> line_valid at N+7, line_tag=0x05, data_0/data_1 match, line_parity_error=0, data_read_error=0.
- Tag 0x10 half 1 at N, half 0 at N+1 (reverse, back-to-back) -> line_valid at N+4, halves correctly ordered; exercises forwarding.
- Interleave tag 0x01 h0, tag 0x02 h0, tag 0x02 h1, tag 0x01 h1 on consecutive cycles -> completions for 0x02 then 0x01, one cycle apart, data not crossed.
- Tag 0x03 h0 with bw_tag_parity flipped -> data_read_error=3'b100 pulse after 3 cycles; the following valid h1 does not complete.
- Tag 0x04 h0 with bw_parity[2] flipped, then good h1 -> data_read_error=3'b010 pulse; line delivered with line_parity_error=1.
- Tag 0x07 h0 twice, then h1; also assert rstn low after a lone h0 on 0x08, then send h1 -> 0x07: dup pulse 3'b001, line delivered with the second h0 data; 0x08: no completion after reset.

Source files
------------

// File: rtl/read_data_control_pkg.sv
// Shared types and parity helpers for the PSL buffer-write receiver.
// Pure definitions; no timing or flow control of its own.
package read_data_control_pkg;

    localparam int TAG_W             = 8;
    localparam int HALF_W            = 512;
    localparam int DW_CNT            = 8;
    localparam int READ_DATA_LATENCY = 3;

    typedef logic [HALF_W-1:0] data_line_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic              tag_parity;
        logic [5:0]        address;
        data_line_t        data;
        logic [DW_CNT-1:0] parity;
    } bw_beat_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        data_line_t       data_0;
        data_line_t       data_1;
        logic             parity_error;
    } line_out_t;

    // Odd parity: the bits together with their parity bit carry an odd count of ones.
    function automatic logic odd_parity_ok(input logic [TAG_W-1:0] bits, input logic par);
        return ^{bits, par};
    endfunction

    function automatic logic dw_parity_err(input data_line_t data, input logic [DW_CNT-1:0] par);
        logic err;
        err = 1'b0;
        for (int i = 0; i < DW_CNT; i++) begin
            err = err | !(^{data[64*i +: 64], par[i]});
        end
        return err;
    endfunction

endpackage

// File: rtl/read_data_control_if.sv
// Buffer-write beat bus into the AFU and the assembled-line bus out of it.
// No handshake: beats are accepted every cycle, lines are single-cycle pulses.
interface read_data_control_if;
    import read_data_control_pkg::*;

    logic              bw_valid;
    logic [TAG_W-1:0]  bw_tag;
    logic              bw_tag_parity;
    logic [5:0]        bw_address;
    data_line_t        bw_data;
    logic [DW_CNT-1:0] bw_parity;

    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    data_line_t        line_data_0;
    data_line_t        line_data_1;
    logic              line_parity_error;

    modport master (
        output bw_valid, bw_tag, bw_tag_parity, bw_address, bw_data, bw_parity,
        input  line_valid, line_tag, line_data_0, line_data_1, line_parity_error
    );

    modport slave (
        input  bw_valid, bw_tag, bw_tag_parity, bw_address, bw_data, bw_parity,
        output line_valid, line_tag, line_data_0, line_data_1, line_parity_error
    );

endinterface

// File: rtl/read_data_control_ram.sv
// Simple dual-port RAM, one write and one registered read port, read returns old data on collision.
// Read latency 1 cycle; no backpressure.
module read_data_control_ram #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/read_data_control.sv
// Assembles the two 64B halves of each tag into a 128B line and checks tag/data parity.
// Latency 3 cycles from the completing beat to line/error outputs; no backpressure, one beat per cycle.
module read_data_control
    import read_data_control_pkg::*;
#(
    parameter int TAG_DEPTH     = 256,
    parameter int ENABLE_ERRORS = 1
) (
    input  logic               clock,
    input  logic               rstn,
    input  logic               enabled_in,
    read_data_control_if.slave bus,
    output logic [2:0]         data_read_error
);

    logic                 enabled;
    bw_beat_t             s0;
    logic [TAG_DEPTH-1:0] seen0, seen1, err_map;

    logic s1_half, s1_tag_err, s1_data_err, s1_accept, s1_complete, s1_dup;
    logic seen_own, seen_other;

    // RAM writes go through a register stage, so a read one cycle later can miss them.
    logic             wr_vld, wr_half;
    logic [TAG_W-1:0] wr_tag;
    data_line_t       wr_data;

    logic             s2_vld, s2_half, s2_perr, s2_fwd;
    logic [TAG_W-1:0] s2_tag;
    data_line_t       s2_data, s2_fwd_data;
    data_line_t       rd_data_0, rd_data_1, other_half;

    logic [2:0] detected_errors;
    line_out_t  line_q;

    always_comb begin
        s1_half     = |s0.address;
        s1_tag_err  = s0.valid & ~odd_parity_ok(s0.tag, s0.tag_parity);
        s1_data_err = s0.valid & dw_parity_err(s0.data, s0.parity);
        seen_own    = s1_half ? seen1[s0.tag] : seen0[s0.tag];
        seen_other  = s1_half ? seen0[s0.tag] : seen1[s0.tag];
        s1_accept   = s0.valid & ~s1_tag_err;
        s1_complete = s1_accept & seen_other;
        s1_dup      = s1_accept & seen_own & ~seen_other;
    end

    read_data_control_ram #(.WIDTH(HALF_W), .DEPTH(TAG_DEPTH)) u_ram_0 (
        .clock (clock),
        .we    (wr_vld & ~wr_half),
        .waddr (wr_tag),
        .wdata (wr_data),
        .re    (s1_complete & s1_half),
        .raddr (s0.tag),
        .rdata (rd_data_0)
    );

    read_data_control_ram #(.WIDTH(HALF_W), .DEPTH(TAG_DEPTH)) u_ram_1 (
        .clock (clock),
        .we    (wr_vld & wr_half),
        .waddr (wr_tag),
        .wdata (wr_data),
        .re    (s1_complete & ~s1_half),
        .raddr (s0.tag),
        .rdata (rd_data_1)
    );

    assign other_half = s2_fwd ? s2_fwd_data : (s2_half ? rd_data_0 : rd_data_1);

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            enabled         <= 1'b0;
            s0              <= '0;
            seen0           <= '0;
            seen1           <= '0;
            err_map         <= '0;
            wr_vld          <= 1'b0;
            wr_half         <= 1'b0;
            wr_tag          <= '0;
            wr_data         <= '0;
            s2_vld          <= 1'b0;
            s2_half         <= 1'b0;
            s2_perr         <= 1'b0;
            s2_fwd          <= 1'b0;
            s2_tag          <= '0;
            s2_data         <= '0;
            s2_fwd_data     <= '0;
            detected_errors <= '0;
            data_read_error <= '0;
            line_q          <= '0;
        end else begin
            enabled  <= enabled_in;
            s0.valid <= bus.bw_valid & enabled;
            if (bus.bw_valid & enabled) begin
                s0.tag        <= bus.bw_tag;
                s0.tag_parity <= bus.bw_tag_parity;
                s0.address    <= bus.bw_address;
                s0.data       <= bus.bw_data;
                s0.parity     <= bus.bw_parity;
            end

            wr_vld <= s1_accept;
            if (s1_accept) begin
                wr_tag  <= s0.tag;
                wr_half <= s1_half;
                wr_data <= s0.data;
                if (seen_other) begin
                    seen0[s0.tag]   <= 1'b0;
                    seen1[s0.tag]   <= 1'b0;
                    err_map[s0.tag] <= 1'b0;
                end else begin
                    if (s1_half) seen1[s0.tag] <= 1'b1;
                    else         seen0[s0.tag] <= 1'b1;
                    err_map[s0.tag] <= err_map[s0.tag] | s1_data_err;
                end
            end

            s2_vld <= s1_complete;
            if (s1_complete) begin
                s2_tag      <= s0.tag;
                s2_half     <= s1_half;
                s2_data     <= s0.data;
                s2_perr     <= err_map[s0.tag] | s1_data_err;
                s2_fwd      <= wr_vld && (wr_tag == s0.tag) && (wr_half != s1_half);
                s2_fwd_data <= wr_data;
            end

            detected_errors <= {s1_tag_err, s1_data_err, s1_dup};
            data_read_error <= (ENABLE_ERRORS != 0) ? detected_errors : 3'b000;

            line_q.valid <= s2_vld;
            if (s2_vld) begin
                line_q.tag          <= s2_tag;
                line_q.data_0       <= s2_half ? other_half : s2_data;
                line_q.data_1       <= s2_half ? s2_data : other_half;
                line_q.parity_error <= s2_perr;
            end
        end
    end

    assign bus.line_valid        = line_q.valid;
    assign bus.line_tag          = line_q.tag;
    assign bus.line_data_0       = line_q.data_0;
    assign bus.line_data_1       = line_q.data_1;
    assign bus.line_parity_error = line_q.parity_error;

endmodule
